temp_alarm_ctrl: RTL
====================

Name: temp_alarm_ctrl

Overview:
Alarm decision stage directly upstream of the buzzer/melody player in the temperature acquisition alarm system. Consumes signed temperature samples from the sensor interface and compares them against programmable high/low thresholds with hysteresis and N-sample confirmation. Produces the 32-bit Audio_Display control word whose bit 0 enables the downstream melody player. Also handles user mute and a maximum sounding time.

Parameters:
TEMP_W, 16, width of signed temperature sample (1/16 °C per LSB)
CONFIRM_N, 4, consecutive over-threshold samples needed to raise alarm (1..15)
MAX_ON_CYCLES, 1_000_000_000, maximum Clk cycles the alarm may sound before auto-mute (10 s at 100 MHz; 32-bit counter)

Ports:
Clk  in  1  system clock, 100 MHz
Reset  in  1  asynchronous, active-low reset
Temp_Data  in  TEMP_W  signed temperature sample
Temp_Valid  in  1  single-cycle strobe; Temp_Data valid this cycle
Th_High  in  TEMP_W  signed raise threshold (alarm when sample > Th_High)
Th_Low  in  TEMP_W  signed clear threshold (clear when sample < Th_Low)
Mute  in  1  single-cycle synchronous mute request
Audio_Display  out  32  control word to melody player
Alarm_State  out  2  current FSM state encoding
Config_Err  out  1  high while Th_Low > Th_High

Behaviour:
- Reset (async, Reset=0): state IDLE, confirm count 0, on-timer 0, event count 0, latched sample 0; Audio_Display=0, Alarm_State=0, Config_Err=0.
- All comparisons are signed, TEMP_W bits. Inputs are sampled only on Clk edges with Temp_Valid=1; Th_High/Th_Low are read on every edge.
- States and encoding: IDLE=0, PENDING=1, ALARM=2, MUTED=3.
- IDLE: valid sample > Th_High -> confirm count=1; go to ALARM if CONFIRM_N==1, else PENDING. Otherwise stay in IDLE.
- PENDING: valid sample > Th_High -> confirm count +1; on reaching CONFIRM_N -> ALARM. Valid sample <= Th_High -> IDLE, confirm count=0. No valid sample -> hold.
- ALARM entry: latch the triggering Temp_Data; event count +1, saturating at 255; on-timer cleared.
- ALARM: on-timer increments each cycle. Priority: valid sample < Th_Low -> IDLE; else Mute=1 -> MUTED; else on-timer == MAX_ON_CYCLES-1 -> MUTED.
- MUTED: silent. Valid sample < Th_Low -> IDLE. Mute ignored. Stays muted while temperature stays >= Th_Low; no re-arm without passing through IDLE.
- Hysteresis band (Th_Low <= sample <= Th_High): ALARM/MUTED hold; IDLE stays IDLE; PENDING returns to IDLE.
- Config_Err = (Th_Low > Th_High), combinational. While asserted:
  - the FSM is forced to IDLE on the next edge;
  - confirm count and on-timer are cleared;
  - event count and latched sample are held.
- Audio_Display is decoded from registers (no extra pipeline):
  - [0] = (state==ALARM)
  - [2:1] = state
  - [7:3] = 0
  - [15:8] = event count
  - [31:16] = latched sample, sign-extended/truncated to 16 bits
- Latency: a qualifying sample at edge k changes state at edge k. Audio_Display[0] is valid immediately after edge k, i.e. one cycle after the strobe.
- Simultaneous events:
  - Mute with a clearing sample in the same cycle -> IDLE.
  - Timeout with a clearing sample in the same cycle -> IDLE.
  - Mute in IDLE or PENDING has no effect.
- Reset mid-ALARM: Audio_Display[0] drops asynchronously and the event count is lost.

Test Plan:
- Reset release with Th_High=480 and Th_Low=448 -> Audio_Display=0x00000000, Alarm_State=0, Config_Err=0.
- Four valid samples of 500 with CONFIRM_N=4 -> states 1,1,1,2; after the 4th strobe edge, Audio_Display=0x01F40105.
- Samples 500,500,470,500 -> PENDING, PENDING, IDLE, PENDING; Audio_Display[0] never high.
- In ALARM, samples of 460 (hysteresis band) -> stays ALARM. Then 440 -> IDLE, Audio_Display[0]=0, event count remains 1.
- In ALARM, pulse Mute -> MUTED, [0]=0, [2:1]=3. Samples of 500 keep MUTED. Sample 440 -> IDLE. Four samples of 500 re-alarm with event count=2.
- MAX_ON_CYCLES=100: enter ALARM and hold temp at 500 -> exactly 100 cycles later, MUTED.
- Same-cycle Mute and sample 440 -> IDLE.
- Th_Low=500 with Th_High=480 -> Config_Err=1 and FSM returns to IDLE.

Source files
------------

// File: rtl/temp_alarm_ctrl.sv
// Temperature alarm decision stage: threshold compare with hysteresis and N-sample
// confirmation, mute/timeout handling, and the Audio_Display control word.
module temp_alarm_ctrl #(
    parameter int          TEMP_W        = 16,
    parameter int          CONFIRM_N     = 4,
    parameter int unsigned MAX_ON_CYCLES = 1_000_000_000
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic signed [TEMP_W-1:0] Temp_Data,
    input  logic                     Temp_Valid,
    input  logic signed [TEMP_W-1:0] Th_High,
    input  logic signed [TEMP_W-1:0] Th_Low,
    input  logic                     Mute,
    output logic [31:0]              Audio_Display,
    output logic [1:0]               Alarm_State,
    output logic                     Config_Err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        ALARM   = 2'd2,
        MUTED   = 2'd3
    } state_t;

    localparam logic [3:0]  CONFIRM_TARGET = 4'(CONFIRM_N);
    localparam logic [31:0] TIMER_LAST     = 32'(MAX_ON_CYCLES - 1);

    state_t                     state_reg, state_next;
    logic [3:0]                 confirm_reg, confirm_next;
    logic [31:0]                timer_reg, timer_next;
    logic [7:0]                 event_reg, event_next;
    logic signed [TEMP_W-1:0]   latched_reg, latched_next;
    logic                       above_high;
    logic                       below_low;
    logic                       enter_alarm;
    logic signed [15:0]         latched_16;

    assign above_high = Temp_Valid && (Temp_Data > Th_High);
    assign below_low  = Temp_Valid && (Temp_Data < Th_Low);
    assign Config_Err = (Th_Low > Th_High);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_reg   <= IDLE;
            confirm_reg <= '0;
            timer_reg   <= '0;
            event_reg   <= '0;
            latched_reg <= '0;
        end else begin
            state_reg   <= state_next;
            confirm_reg <= confirm_next;
            timer_reg   <= timer_next;
            event_reg   <= event_next;
            latched_reg <= latched_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        confirm_next = confirm_reg;
        timer_next   = timer_reg;
        event_next   = event_reg;
        latched_next = latched_reg;
        enter_alarm  = 1'b0;

        if (Config_Err) begin
            // Bad thresholds: park in IDLE, keep the event history visible.
            state_next   = IDLE;
            confirm_next = '0;
            timer_next   = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (above_high) begin
                        confirm_next = 4'd1;
                        if (CONFIRM_N == 1) enter_alarm = 1'b1;
                        else                state_next  = PENDING;
                    end
                end
                PENDING: begin
                    if (above_high) begin
                        if (confirm_reg + 4'd1 == CONFIRM_TARGET) enter_alarm  = 1'b1;
                        else                                      confirm_next = confirm_reg + 4'd1;
                    end else if (Temp_Valid) begin
                        state_next   = IDLE;
                        confirm_next = '0;
                    end
                end
                ALARM: begin
                    timer_next = timer_reg + 32'd1;
                    if (below_low) begin
                        state_next = IDLE;
                        timer_next = '0;
                    end else if (Mute || (timer_reg == TIMER_LAST)) begin
                        state_next = MUTED;
                    end
                end
                MUTED: begin
                    // Only a clearing sample re-arms; Mute is meaningless here.
                    if (below_low) begin
                        state_next = IDLE;
                        timer_next = '0;
                    end
                end
                default: state_next = IDLE;
            endcase
        end

        if (enter_alarm) begin
            state_next   = ALARM;
            confirm_next = '0;
            timer_next   = '0;
            latched_next = Temp_Data;
            if (event_reg != 8'hFF) event_next = event_reg + 8'd1;
        end
    end

    generate
        if (TEMP_W >= 16) begin : g_trunc
            assign latched_16 = latched_reg[15:0];
        end else begin : g_sext
            assign latched_16 = {{(16-TEMP_W){latched_reg[TEMP_W-1]}}, latched_reg};
        end
    endgenerate

    assign Audio_Display = {latched_16, event_reg, 5'd0, state_reg, (state_reg == ALARM)};
    assign Alarm_State   = state_reg;

endmodule
